// File: rtl/stack_reg_bank.sv
// General-purpose register bank with status register, stack pointer and a
// self-timed push/pop sequencer that drives the shared RAM port directly.
module stack_reg_bank #(
    parameter int               WIDTH       = 16,
    parameter int               NUM_REGS    = 14,
    parameter logic [WIDTH-1:0] STACK_BASE  = 16'hFFFF,
    parameter logic [WIDTH-1:0] STACK_LIMIT = 16'hFF00,
    parameter int               RAM_LAT     = 1,
    parameter int               FLAG_W      = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [WIDTH-1:0]                  bus_in,
    input  logic [NUM_REGS-1:0]               rin,
    input  logic [$clog2(NUM_REGS+2)-1:0]     rsel,
    input  logic                              rout_en,
    output logic [WIDTH-1:0]                  bus_out,
    input  logic                              sr_load,
    input  logic                              sr_sel,
    input  logic [FLAG_W-1:0]                 alu_flags,
    output logic [FLAG_W-1:0]                 sr_out,
    input  logic                              sp_load,
    input  logic                              push_req,
    input  logic                              pop_req,
    input  logic [$clog2(NUM_REGS)-1:0]       stack_reg,
    output logic                              busy,
    output logic                              done,
    output logic                              ovf_err,
    output logic                              unf_err,
    input  logic                              err_clr,
    output logic                              ram_req,
    output logic [WIDTH-1:0]                  ram_addr,
    output logic [WIDTH-1:0]                  ram_wdata,
    output logic                              ram_wren,
    input  logic [WIDTH-1:0]                  ram_rdata
);

    localparam int RSEL_W   = $clog2(NUM_REGS + 2);
    localparam int REG_W    = $clog2(NUM_REGS);
    localparam int WAIT_CYC = RAM_LAT - 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PUSH_WR  = 3'd1;
    localparam logic [2:0] ST_POP_RD   = 3'd2;
    localparam logic [2:0] ST_POP_WAIT = 3'd3;
    localparam logic [2:0] ST_POP_WB   = 3'd4;

    localparam logic [RSEL_W-1:0] SEL_SR = RSEL_W'(NUM_REGS);
    localparam logic [RSEL_W-1:0] SEL_SP = RSEL_W'(NUM_REGS + 1);

    logic [WIDTH-1:0]  gpr_q [NUM_REGS];
    logic [WIDTH-1:0]  gpr_d [NUM_REGS];
    logic [FLAG_W-1:0] sr_q, sr_d;
    logic [WIDTH-1:0]  sp_q, sp_d;
    logic [2:0]        state_q, state_d;
    logic [REG_W-1:0]  reg_q, reg_d;
    logic [3:0]        wait_q, wait_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              ram_req_q, ram_req_d;
    logic              ram_wren_q, ram_wren_d;
    logic [WIDTH-1:0]  ram_addr_q, ram_addr_d;
    logic [WIDTH-1:0]  ram_wdata_q, ram_wdata_d;
    logic [WIDTH-1:0]  push_src;
    logic [WIDTH-1:0]  rd_val;

    // Pop writeback has priority over a bus load of the same register.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            gpr_d[i] = gpr_q[i];
            if (state_q == ST_POP_WB && reg_q == REG_W'(i)) begin
                gpr_d[i] = ram_rdata;
            end else if (rin[i]) begin
                gpr_d[i] = bus_in;
            end
        end
    end

    // Push data is the register value as it stands during PUSH_WR, so a
    // same-cycle bus load of the source register is included.
    always_comb begin
        push_src = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (stack_reg == REG_W'(i)) push_src = gpr_d[i];
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rsel == RSEL_W'(i)) rd_val = gpr_q[i];
        end
        if (rsel == SEL_SR) rd_val = WIDTH'(sr_q);
        if (rsel == SEL_SP) rd_val = sp_q;
    end

    always_comb begin
        state_d     = state_q;
        reg_d       = reg_q;
        wait_d      = wait_q;
        sp_d        = sp_q;
        sr_d        = sr_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        ram_req_d   = 1'b0;
        ram_wren_d  = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;

        // Clear first so that a same-cycle error event below wins.
        if (err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (sr_load) sr_d = sr_sel ? alu_flags : bus_in[FLAG_W-1:0];

        case (state_q)
            ST_IDLE: begin
                if (sp_load) begin
                    sp_d = bus_in;
                end else if (push_req) begin
                    if (sp_q == STACK_LIMIT) begin
                        ovf_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d     = ST_PUSH_WR;
                        reg_d       = stack_reg;
                        ram_req_d   = 1'b1;
                        ram_wren_d  = 1'b1;
                        ram_addr_d  = sp_q - WIDTH'(1);
                        ram_wdata_d = push_src;
                    end
                end else if (pop_req) begin
                    if (sp_q == STACK_BASE) begin
                        unf_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d    = ST_POP_RD;
                        reg_d      = stack_reg;
                        ram_req_d  = 1'b1;
                        ram_addr_d = sp_q;
                    end
                end
            end
            ST_PUSH_WR: begin
                sp_d    = sp_q - WIDTH'(1);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_POP_RD: begin
                if (WAIT_CYC == 0) begin
                    state_d = ST_POP_WB;
                end else begin
                    state_d = ST_POP_WAIT;
                    wait_d  = 4'(WAIT_CYC - 1);
                end
            end
            ST_POP_WAIT: begin
                if (wait_q == 4'd0) state_d = ST_POP_WB;
                else                wait_d  = wait_q - 4'd1;
            end
            ST_POP_WB: begin
                sp_d    = sp_q + WIDTH'(1);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) gpr_q[i] <= '0;
            sr_q        <= '0;
            sp_q        <= STACK_BASE;
            state_q     <= ST_IDLE;
            reg_q       <= '0;
            wait_q      <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            ram_req_q   <= 1'b0;
            ram_wren_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) gpr_q[i] <= gpr_d[i];
            sr_q        <= sr_d;
            sp_q        <= sp_d;
            state_q     <= state_d;
            reg_q       <= reg_d;
            wait_q      <= wait_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            ram_req_q   <= ram_req_d;
            ram_wren_q  <= ram_wren_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign bus_out   = rout_en ? rd_val : '0;
    assign sr_out    = sr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;
    assign ram_req   = ram_req_q;
    assign ram_wren  = ram_wren_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: doc/stack_reg_bank.md
Name: stack_reg_bank

Overview:
- Parametrised general-purpose register bank with an integrated status register (SR), stack pointer (SP) and push/pop sequencer, for the bus-based CPU datapath.
- Replaces the fixed 14-register / SP / SR arrangement and its tristate buffers with:
  - a point-to-point bus_in / bus_out interface;
  - configurable width, register count and stack bounds;
  - a self-timed PUSH/POP engine that drives the shared RAM port directly, with overflow/underflow detection.

Parameters:
- WIDTH, 16, data and address width.
- NUM_REGS, 14, number of GPRs (>=2).
- STACK_BASE, 16'hFFFF, SP reset value; SP==STACK_BASE means the stack is empty.
- STACK_LIMIT, 16'hFF00, lowest legal SP; SP==STACK_LIMIT means the stack is full.
- RAM_LAT, 1, read latency of the RAM (1 or 2 cycles) from address presentation to valid ram_rdata.
- FLAG_W, 4, status flag width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- bus_in  in  WIDTH  datapath bus value
- rin  in  NUM_REGS  per-GPR load enables (one-hot or multi-hot)
- rsel  in  clog2(NUM_REGS+2)  read select: 0..NUM_REGS-1 = GPR, NUM_REGS = SR, NUM_REGS+1 = SP
- rout_en  in  1  enables bus_out
- bus_out  out  WIDTH  selected register value; zero when rout_en=0
- sr_load  in  1  SR load strobe
- sr_sel  in  1  SR source: 0 = bus_in[FLAG_W-1:0], 1 = alu_flags
- alu_flags  in  FLAG_W  ALU status flags
- sr_out  out  FLAG_W  current SR
- sp_load  in  1  load SP from bus_in
- push_req  in  1  push request (single-cycle strobe)
- pop_req  in  1  pop request (single-cycle strobe)
- stack_reg  in  clog2(NUM_REGS)  push source / pop destination GPR
- busy  out  1  sequencer not idle
- done  out  1  one-cycle pulse at the end of every accepted push/pop, including faulted ones
- ovf_err  out  1  sticky: push attempted while full
- unf_err  out  1  sticky: pop attempted while empty
- err_clr  in  1  clears ovf_err and unf_err
- ram_req  out  1  sequencer owns the RAM port this cycle
- ram_addr  out  WIDTH  RAM address (valid when ram_req=1)
- ram_wdata  out  WIDTH  RAM write data
- ram_wren  out  1  RAM write enable
- ram_rdata  in  WIDTH  RAM read data

Behaviour:
- Reset (async, rst=1):
  - all GPRs=0, SR=0, SP=STACK_BASE, state=IDLE;
  - busy, done, ovf_err, unf_err, ram_req, ram_wren = 0;
  - ram_addr = 0, ram_wdata = 0.
- Reset asserted mid-operation aborts the push/pop: no RAM write completes after rst rises, and no GPR writeback occurs.
- GPR writes: on a clock edge, every GPR i with rin[i]=1 loads bus_in.
- Read path: bus_out is combinational from rsel.
  - SR is zero-extended to WIDTH.
  - An rsel value >= NUM_REGS+2 reads 0.
- SR: when sr_load=1, SR loads the source chosen by sr_sel. sr_out reflects the SR register.
- SP:
  - sp_load loads bus_in only in IDLE; it is ignored while busy.
  - If sp_load and push_req/pop_req arrive in the same cycle, sp_load wins and the request is dropped.
- Sequencer states: IDLE, PUSH_WR, POP_RD, POP_WAIT, POP_WB.
- IDLE:
  - push_req and pop_req together: push wins; the pop is dropped.
  - push_req with SP==STACK_LIMIT: set ovf_err, pulse done next cycle, stay IDLE, no RAM access.
  - push_req otherwise: go to PUSH_WR, latching stack_reg.
  - pop_req with SP==STACK_BASE: set unf_err, pulse done next cycle, stay IDLE.
  - pop_req otherwise: go to POP_RD, latching stack_reg.
  - Requests arriving while busy=1 are ignored (not queued).
- PUSH_WR (1 cycle):
  - ram_req=1, ram_wren=1, ram_addr=SP-1, ram_wdata=GPR[latched reg];
  - SP<=SP-1, done=1 on the next cycle, return to IDLE.
  - Push latency is 2 cycles from request to done.
- POP_RD:
  - ram_req=1, ram_addr=SP;
  - go to POP_WAIT for RAM_LAT-1 further cycles (skipped when RAM_LAT=1), then POP_WB.
- POP_WB:
  - GPR[latched reg]<=ram_rdata, SP<=SP+1, done=1, return to IDLE.
  - In the same cycle, a POP_WB writeback overrides any rin write to that GPR.
  - rin writes to other GPRs proceed normally during pop.
  - Pop latency is RAM_LAT+2 cycles from request to done.
- busy=1 in every state except IDLE.
- ram_addr holds its last value when ram_req=0.
- SP arithmetic is modulo 2^WIDTH. Bounds checks use equality only, so software must keep SP within [STACK_LIMIT, STACK_BASE].
- Sticky errors: err_clr and an error-setting event in the same cycle leave the error flag set.

Test Plan:
- Reset, then read SP via rsel=NUM_REGS+1 with rout_en=1 -> bus_out=16'hFFFF; all GPRs read 0; busy=0.
- Load GPR3=16'h1234 via rin, then push_req with stack_reg=3:
  - next cycle ram_wren=1, ram_addr=16'hFFFE, ram_wdata=16'h1234;
  - done pulses after that; SP reads 16'hFFFE.
- After that push, pop_req with stack_reg=5, RAM model returning 16'h1234 at RAM_LAT=1 -> GPR5=16'h1234, SP=16'hFFFF, done exactly 3 cycles after request.
- pop_req at SP=STACK_BASE -> unf_err=1, no ram_req, SP unchanged. Then err_clr -> unf_err=0.
- sp_load with bus_in=STACK_LIMIT, then push_req -> ovf_err=1, no RAM write. Also: push_req and pop_req in the same cycle at a non-full SP -> only the push executes.
- During a pop (RAM_LAT=2), raise rin for the destination GPR with bus_in=16'hAAAA in the POP_WB cycle -> GPR holds ram_rdata. Separately, assert rst during POP_WAIT -> state IDLE, SP=STACK_BASE, no writeback.
